// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for a shared N-input data mux.
// One requester is picked per accepted beat. Its word is registered into a
// valid/ready output stage, and ack_out tells that requester its word was taken.
// Optional feature macro: MUX_ARB_BURST_EN. When it is defined, the current winner
// keeps top priority for up to BURST_LEN consecutive beats.
module mux_rr_arbiter #(
    parameter int DAT_WIDTH = 8,
    parameter int SEL_WIDTH = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic [(2**SEL_WIDTH)-1:0]       req_in,
    input  logic [(2**SEL_WIDTH)*DAT_WIDTH-1:0] mux_in,
    output logic [(2**SEL_WIDTH)-1:0]       ack_out,
    output logic [SEL_WIDTH-1:0]            sel_out,
    output logic [DAT_WIDTH-1:0]            out_data_out,
    output logic                            out_valid_out,
    input  logic                            out_ready_in
);

    localparam int N = 2**SEL_WIDTH;

    // A burst length below one has no meaning; reject it at elaboration.
    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("mux_rr_arbiter: BURST_LEN must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DAT_WIDTH-1:0]   data_q,  data_d;
    logic [SEL_WIDTH-1:0]   sel_q,   sel_d;
    logic [SEL_WIDTH-1:0]   ptr_q,   ptr_d;

    logic                   any_req;
    logic                   load;
    logic                   found;
    logic [SEL_WIDTH-1:0]   idx;
    logic [SEL_WIDTH-1:0]   win;

`ifdef MUX_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   hold;

    // The last winner keeps the grant while it still requests and has burst budget left.
    assign hold = (cnt_q != '0) && (cnt_q < CW'(BURST_LEN)) && req_in[ptr_q];
`endif

    // A new beat can enter when something is requested and the output slot is free or draining.
    assign any_req = |req_in;
    assign load    = any_req && ((state_q == IDLE) || out_ready_in);

    // Rotating priority search that starts just above the last-grant pointer and wraps mod N.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            // SEL_WIDTH-bit addition wraps naturally; k == N lands back on ptr_q itself.
            idx = ptr_q + SEL_WIDTH'(k);
            if (!found && req_in[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
`ifdef MUX_ARB_BURST_EN
        if (hold) begin
            win = ptr_q;
        end
`endif
    end

    // Acknowledge the winner in the same cycle its word is captured.
    always_comb begin
        ack_out = '0;
        if (load) begin
            ack_out[win] = 1'b1;
        end
    end

    // Next-state and datapath capture for the single-entry output stage.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready_in && !any_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            data_d = mux_in[int'(win)*DAT_WIDTH +: DAT_WIDTH];
            sel_d  = win;
            ptr_d  = win;
        end
    end

`ifdef MUX_ARB_BURST_EN
    // Burst beat counter: it restarts for every new winner and is cleared when the owner drops its request.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = hold ? (cnt_q + CW'(1)) : CW'(1);
        end else if (!req_in[ptr_q]) begin
            cnt_d = '0;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Output stage and pointer registers. Reset drops any held beat.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_WIDTH'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid_out = (state_q == FULL);
    assign sel_out       = sel_q;
    assign out_data_out  = data_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter. Vectors come from a table, with hand sequences for reset and bursts.
// A scoreboard queue holds the expected output beats.
module tb_mux_rr_arbiter;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam int N  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   mux;
    logic [N-1:0]      ack;
    logic [SW-1:0]     sel;
    logic [DW-1:0]     dout;
    logic              vout;
    logic              rdy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic         v;
        logic [N-1:0] ack;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .DAT_WIDTH(DW),
        .SEL_WIDTH(SW),
        .BURST_LEN(4)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_in        (req),
        .mux_in        (mux),
        .ack_out       (ack),
        .sel_out       (sel),
        .out_data_out  (dout),
        .out_valid_out (vout),
        .out_ready_in  (rdy)
    );

    function automatic logic [DW-1:0] word_of(int i);
        if (i == 3) return 8'hA5;
        return 8'(8'h11 * i + 8'h07);
    endfunction

    function automatic vec_t mk(logic [N-1:0] r, logic y, logic v, logic [N-1:0] a);
        vec_t t;
        t.req = r;
        t.rdy = y;
        t.v   = v;
        t.ack = a;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle. Outputs are checked at the negedge, then the scoreboard is updated.
    task automatic step(input logic [N-1:0] r, input logic y, input logic v,
                        input logic [N-1:0] a, input string nm);
        req = r;
        rdy = y;
        @(negedge clk);
        check({nm, " valid"}, 32'(vout), 32'(v));
        check({nm, " ack"},   32'(ack),  32'(a));
        if (v) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s sb_empty: got valid beat sel=%0h, expected none queued", nm, sel);
            end else begin
                check({nm, " sel"},  32'(sel),  32'(sb[0].sel));
                check({nm, " data"}, 32'(dout), 32'(sb[0].data));
                if (y) void'(sb.pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            if (a[i]) sb.push_back('{SW'(i), word_of(i)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("reset valid", 32'(vout), 32'd0);
        check("reset ack",   32'(ack),  32'd0);
        check("reset sel",   32'(sel),  32'd0);
        check("reset data",  32'(dout), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        rdy   = 1'b0;
        for (int i = 0; i < N; i++) mux[i*DW +: DW] = word_of(i);

        do_reset();

`ifdef MUX_ARB_BURST_EN
        begin : burst_tests
            int exp_b[9] = '{2, 2, 2, 2, 5, 5, 5, 5, 2};
            for (int k = 0; k < 9; k++)
                step(16'h0024, 1'b1, k > 0, 16'(1) << exp_b[k], "burst");
            step(16'h0000, 1'b1, 1'b1, 16'h0000, "burst drain");
            do_reset();
            step(16'h0024, 1'b1, 1'b0, 16'h0004, "pre-reset burst");
            step(16'h0024, 1'b1, 1'b1, 16'h0004, "pre-reset burst");
            do_reset();
            for (int k = 0; k < 5; k++)
                step(16'h0024, 1'b1, k > 0, (k < 4) ? 16'h0004 : 16'h0020, "post-reset burst");
            step(16'h0000, 1'b1, 1'b1, 16'h0000, "burst drain2");
        end
`else
        // Single request, backpressure, wrap and withdraw, starting from ptr = 15.
        tbl.push_back(mk(16'h0008, 1'b1, 1'b0, 16'h0008));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 16'h0000));
        tbl.push_back(mk(16'h0030, 1'b1, 1'b0, 16'h0010));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(16'h0020, 1'b0, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0020, 1'b1, 1'b1, 16'h0020));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 16'h0000));
        tbl.push_back(mk(16'h4000, 1'b1, 1'b0, 16'h4000));
        tbl.push_back(mk(16'h8001, 1'b1, 1'b1, 16'h8000));
        tbl.push_back(mk(16'h0001, 1'b1, 1'b1, 16'h0001));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 16'h0000));
        tbl.push_back(mk(16'h0004, 1'b1, 1'b0, 16'h0004));
        tbl.push_back(mk(16'h0008, 1'b0, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 16'h0000));
        tbl.push_back(mk(16'h0000, 1'b1, 1'b0, 16'h0000));
        foreach (tbl[i]) step(tbl[i].req, tbl[i].rdy, tbl[i].v, tbl[i].ack, $sformatf("vec%0d", i));

        // Reset while a beat is held in a stall.
        step(16'h0100, 1'b0, 1'b0, 16'h0100, "midrst load");
        step(16'h0000, 1'b0, 1'b1, 16'h0000, "midrst stall");
        do_reset();

        // All requesting: 0..15, 0, 1 from the reset pointer.
        for (int k = 0; k < 18; k++)
            step(16'hFFFF, 1'b1, k > 0, 16'(1) << (k % 16), "rr");
        step(16'h0000, 1'b1, 1'b1, 16'h0000, "rr drain");
        step(16'h0000, 1'b1, 1'b0, 16'h0000, "rr idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
